// File: rtl/shift_sched.sv
// Two-port round-robin sequencer for the shared 8-bit barrel shifter.
// Accepts one job at a time, runs it through the external shifter and holds the result until taken.
module shift_sched #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_data,
    input  logic [2:0] req0_num,
    input  logic [1:0] req0_ctl,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_data,
    input  logic [2:0] req1_num,
    input  logic [1:0] req1_ctl,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_data,
    output logic [7:0] sh_in,
    output logic [2:0] sh_num,
    output logic [1:0] sh_ctl,
    input  logic [7:0] sh_out,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_pri;
    logic       r_gid;
    logic [7:0] r_data;
    logic [2:0] r_num;
    logic [1:0] r_ctl;
    logic [7:0] r_res;

    logic       w_grant0;
    logic       w_grant1;
    logic       w_fire;
    logic       w_sel;
    logic       w_rsp_valid;
    logic       w_done;

    // Arbitration: a lone requester always wins, a tie goes to the priority port.
    assign w_grant0 = req0_valid & (~req1_valid | ~r_pri);
    assign w_grant1 = req1_valid & (~req0_valid |  r_pri);
    assign w_sel    = w_grant1;

    // Next-state and handshake decode.
    always_comb begin
        w_next_state = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        w_fire       = 1'b0;
        w_rsp_valid  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = w_grant0 & ~rst;
                req1_ready = w_grant1 & ~rst;
                if (w_grant0 | w_grant1) begin
                    w_fire       = 1'b1;
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid = ~rst;
                if (r_gid ? rsp1_ready : rsp0_ready) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, operand, result and priority registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pri   <= FIRST_PRIO;
            r_gid   <= 1'b0;
            r_data  <= 8'd0;
            r_num   <= 3'd0;
            r_ctl   <= 2'd0;
            r_res   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_fire) begin
                r_gid  <= w_sel;
                r_data <= w_sel ? req1_data : req0_data;
                r_num  <= w_sel ? req1_num  : req0_num;
                r_ctl  <= w_sel ? req1_ctl  : req0_ctl;
            end
            if (r_state == ST_EXEC) begin
                r_res <= sh_out;
            end
            if (w_done) begin
                r_pri <= ~r_gid;
            end
        end
    end

    // The shifter is always fed from the operand registers so its inputs never glitch.
    assign sh_in      = r_data;
    assign sh_num     = r_num;
    assign sh_ctl     = r_ctl;
    assign rsp0_valid = w_rsp_valid & ~r_gid;
    assign rsp1_valid = w_rsp_valid &  r_gid;
    assign rsp0_data  = r_res;
    assign rsp1_data  = r_res;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// Randomized self-checking bench for shift_sched with a transaction-level reference model
// and a behavioural stand-in for the external barrel shifter.
module tb_shift_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
    logic [2:0] req0_num = 3'd0, req1_num = 3'd0;
    logic [1:0] req0_ctl = 2'd0, req1_ctl = 2'd0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [7:0] rsp0_data, rsp1_data;
    logic [7:0] sh_in, sh_out;
    logic [2:0] sh_num;
    logic [1:0] sh_ctl;
    logic       busy;

    shift_sched #(.FIRST_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_num(req0_num), .req0_ctl(req0_ctl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_num(req1_num), .req1_ctl(req1_ctl),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .sh_in(sh_in), .sh_num(sh_num), .sh_ctl(sh_ctl), .sh_out(sh_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External shifter stand-in: one bit position per step.
    always_comb begin
        logic [7:0] x;
        x = sh_in;
        for (int i = 0; i < 7; i++) begin
            if (i < int'(sh_num)) begin
                case (sh_ctl)
                    2'd0:    x = {x[6:0], 1'b0};
                    2'd1:    x = {1'b0, x[7:1]};
                    2'd2:    x = {x[7], x[7:1]};
                    default: x = {x[0], x[7:1]};
                endcase
            end
        end
        sh_out = x;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle model %0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_shift(logic [7:0] d, logic [2:0] n, logic [1:0] c);
        logic [15:0] w;
        case (c)
            2'd0:    w = {8'd0, d} << n;
            2'd1:    w = {8'd0, d >> n};
            2'd2:    w = {8'd0, 8'($signed(d) >>> n)};
            default: w = {d, d} >> n;
        endcase
        return w[7:0];
    endfunction

    // Stimulus knobs
    logic       want0 = 1'b0, want1 = 1'b0;
    logic       fix0 = 1'b0, fix1 = 1'b0;
    logic [7:0] fd0 = 8'd0, fd1 = 8'd0;
    logic [2:0] fn0 = 3'd0, fn1 = 3'd0;
    logic [1:0] fc0 = 2'd0, fc1 = 2'd0;
    logic       rdy0 = 1'b1, rdy1 = 1'b1, rst_k = 1'b1;
    logic       p0 = 1'b0, p1 = 1'b0;

    // Reference model: transaction-level view of the block
    logic       m_known = 1'b0;
    logic       m_inflight = 1'b0;
    logic       m_gid = 1'b0;
    logic       m_pri = 1'b0;
    int         m_tacc = 0;
    int         cyc = 0;
    logic [7:0] m_d = 8'd0, m_res = 8'd0;
    logic [2:0] m_n = 3'd0;
    logic [1:0] m_c = 2'd0;
    int         grants1 = 0;

    task automatic run_cycle();
        logic e_r0, e_r1, e_v0, e_v1, resp_due;
        @(negedge clk);
        if (!p0 && want0) begin
            p0 = 1'b1;
            req0_data = fix0 ? fd0 : 8'($urandom);
            req0_num  = fix0 ? fn0 : 3'($urandom);
            req0_ctl  = fix0 ? fc0 : 2'($urandom);
        end
        if (!p1 && want1) begin
            p1 = 1'b1;
            req1_data = fix1 ? fd1 : 8'($urandom);
            req1_num  = fix1 ? fn1 : 3'($urandom);
            req1_ctl  = fix1 ? fc1 : 2'($urandom);
        end
        req0_valid = p0;
        req1_valid = p1;
        rsp0_ready = rdy0;
        rsp1_ready = rdy1;
        rst        = rst_k;
        #1;
        resp_due = m_inflight && (cyc >= m_tacc + 2);
        e_r0 = !rst && m_known && !m_inflight && p0 && (!p1 || !m_pri);
        e_r1 = !rst && m_known && !m_inflight && p1 && (!p0 ||  m_pri);
        e_v0 = !rst && resp_due && !m_gid;
        e_v1 = !rst && resp_due &&  m_gid;
        chk("req0_ready", {7'd0, req0_ready}, {7'd0, e_r0});
        chk("req1_ready", {7'd0, req1_ready}, {7'd0, e_r1});
        chk("rsp0_valid", {7'd0, rsp0_valid}, {7'd0, e_v0});
        chk("rsp1_valid", {7'd0, rsp1_valid}, {7'd0, e_v1});
        if (m_known) begin
            chk("busy",      {7'd0, busy}, {7'd0, m_inflight});
            chk("sh_in",     sh_in, m_d);
            chk("sh_num",    {5'd0, sh_num}, {5'd0, m_n});
            chk("sh_ctl",    {6'd0, sh_ctl}, {6'd0, m_c});
            chk("rsp0_data", rsp0_data, m_res);
            chk("rsp1_data", rsp1_data, m_res);
        end
        // Advance the driver on the observed handshake and the model on its own rules.
        if (req0_valid && req0_ready) p0 = 1'b0;
        if (req1_valid && req1_ready) p1 = 1'b0;
        if (rst) begin
            m_known = 1'b1; m_inflight = 1'b0; m_pri = 1'b0;
            m_d = 8'd0; m_n = 3'd0; m_c = 2'd0; m_res = 8'd0;
        end else begin
            if (m_inflight && cyc == m_tacc + 1) m_res = ref_shift(m_d, m_n, m_c);
            if (e_r0 || e_r1) begin
                m_inflight = 1'b1;
                m_gid  = e_r1;
                m_tacc = cyc;
                m_d = e_r1 ? req1_data : req0_data;
                m_n = e_r1 ? req1_num  : req0_num;
                m_c = e_r1 ? req1_ctl  : req0_ctl;
                if (e_r1) grants1++;
            end else if (resp_due && (m_gid ? rsp1_ready : rsp0_ready)) begin
                m_inflight = 1'b0;
                m_pri = !m_gid;
            end
        end
        cyc++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic drain();
        want0 = 1'b0; want1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
        run_n(8);
    endtask

    initial begin
        // Reset
        rst_k = 1'b1;
        run_n(2);
        rst_k = 1'b0;
        run_n(1);

        // Single port-0 shift-left job
        fix0 = 1'b1; fd0 = 8'h0F; fn0 = 3'd4; fc0 = 2'd0;
        want0 = 1'b1;
        run_n(1);
        want0 = 1'b0;
        run_n(1);
        chk("tp_busy_exec", {7'd0, busy}, 8'd1);
        run_n(1);
        chk("tp_shl_data", rsp0_data, 8'hF0);
        drain();

        // Both ports contending every cycle
        fix0 = 1'b1; fd0 = 8'h81; fn0 = 3'd1; fc0 = 2'd3;
        fix1 = 1'b1; fd1 = 8'hF0; fn1 = 3'd3; fc1 = 2'd1;
        want0 = 1'b1; want1 = 1'b1;
        run_n(15);
        drain();

        // Port 1 alone, back-to-back
        grants1 = 0;
        want1 = 1'b1;
        run_n(12);
        want1 = 1'b0;
        chk("tp_p1_alone_grants", 8'(grants1), 8'd4);
        drain();

        // Back-pressure on port 0 with port 1 waiting
        fd0 = 8'h80; fn0 = 3'd1; fc0 = 2'd2;
        rdy0 = 1'b0;
        want0 = 1'b1;
        run_n(1);
        want0 = 1'b0; want1 = 1'b1;
        run_n(6);
        chk("tp_bp_data", rsp0_data, 8'hC0);
        rdy0 = 1'b1;
        run_n(5);
        drain();

        // Reset during RESP after priority has moved to port 1
        fd0 = 8'h3C; fn0 = 3'd2; fc0 = 2'd0;
        want0 = 1'b1;
        run_n(1);
        want0 = 1'b0;
        run_n(4);
        rdy0 = 1'b0;
        want0 = 1'b1;
        run_n(4);
        want0 = 1'b0;
        rst_k = 1'b1;
        run_n(1);
        rst_k = 1'b0;
        rdy0 = 1'b1;
        want0 = 1'b1; want1 = 1'b1;
        run_n(6);
        drain();

        // Zero amount leaves the operand untouched for every op
        for (int c = 0; c < 4; c++) begin
            fd0 = 8'hA5; fn0 = 3'd0; fc0 = 2'(c);
            want0 = 1'b1;
            run_n(1);
            want0 = 1'b0;
            run_n(2);
            chk("tp_num0", rsp0_data, 8'hA5);
            run_n(1);
        end
        drain();

        // Randomized traffic with random back-pressure and occasional reset
        fix0 = 1'b0; fix1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            want0 = ($urandom_range(0, 3) != 0);
            want1 = ($urandom_range(0, 2) != 0);
            rdy0  = ($urandom_range(0, 2) != 0);
            rdy1  = ($urandom_range(0, 3) != 0);
            rst_k = ($urandom_range(0, 199) == 0);
            run_cycle();
        end
        rst_k = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
